// File: rtl/wave_seq_ctrl.sv
// Address sequencer for the 16-entry waveform ROM: programmable sample rate,
// period-aligned waveform switching, continuous / one-shot playback and clean stop.
module wave_seq_ctrl #(
   parameter int DIV_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             one_shot,
   input  logic [DIV_W-1:0] div,
   input  logic [1:0]       sw_req,
   output logic [3:0]       addr,
   output logic             sw3,
   output logic             sw4,
   output logic             sample_stb,
   output logic             period_done,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                          state_q, state_d;
   logic [SYNC_STAGES-1:0][1:0]     sync_q;
   logic [1:0]                      sw_sync;
   logic [3:0]                      addr_q, addr_d;
   logic [1:0]                      sel_q, sel_d;
   logic [DIV_W-1:0]                cnt_q, cnt_d;
   logic [DIV_W-1:0]                div_q, div_d;
   logic                            os_q, os_d;
   logic                            stb_q, stb_d;
   logic                            pd_q, pd_d;
   logic                            tick;
   logic                            wrap;

   assign sw_sync = sync_q[SYNC_STAGES-1];
   assign tick    = (cnt_q == div_q);
   assign wrap    = tick && (addr_q == 4'hF);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sync_q  <= '0;
         addr_q  <= 4'd0;
         sel_q   <= 2'b00;
         cnt_q   <= '0;
         div_q   <= '0;
         os_q    <= 1'b0;
         stb_q   <= 1'b0;
         pd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_req};
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         os_q    <= os_d;
         stb_q   <= stb_d;
         pd_q    <= pd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      os_d    = os_q;
      stb_d   = 1'b0;
      pd_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // Select follows the switches so the ROM previews the chosen waveform.
            addr_d = 4'd0;
            cnt_d  = '0;
            sel_d  = sw_sync;
            if (en) begin
               state_d = RUN;
               div_d   = div;
               os_d    = one_shot;
            end
         end
         RUN, DRAIN: begin
            if (tick) begin
               cnt_d  = '0;
               addr_d = addr_q + 4'd1;
               stb_d  = 1'b1;
            end else begin
               cnt_d  = cnt_q + 1'b1;
            end
            // Period boundary: the only point where select, rate and mode may change.
            if (wrap) begin
               pd_d    = 1'b1;
               sel_d   = sw_sync;
               div_d   = div;
               os_d    = one_shot;
               state_d = (os_q || !en) ? IDLE : RUN;
            end else begin
               state_d = en ? RUN : DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign addr        = addr_q;
   assign sw3         = sel_q[0];
   assign sw4         = sel_q[1];
   assign sample_stb  = stb_q;
   assign period_done = pd_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Directed bench for wave_seq_ctrl: stepping, rate, switch alignment, one-shot, drain and reset.
module tb_wave_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        one_shot;
   logic [15:0] div;
   logic [1:0]  sw_req;
   logic [3:0]  addr;
   logic        sw3, sw4, sample_stb, period_done, busy;

   int n_tests = 0;
   int n_fail  = 0;

   wave_seq_ctrl #(.DIV_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .en(en), .one_shot(one_shot), .div(div),
      .sw_req(sw_req), .addr(addr), .sw3(sw3), .sw4(sw4),
      .sample_stb(sample_stb), .period_done(period_done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"}, addr, 0);
      chk({tag, "_sel"}, {sw4, sw3}, 0);
      chk({tag, "_stb"}, sample_stb, 0);
      chk({tag, "_pd"}, period_done, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   int stb_cnt, pd_cnt;
   int ok;

   initial begin
      en = 1'b0; one_shot = 1'b0; div = 16'd0; sw_req = 2'b00; rst = 1'b0;
      do_reset();
      chk_reset_vals("reset");

      // Test 1: div=0 continuous stepping
      en = 1'b1;
      tick();
      chk("t1_enter_busy", busy, 1);
      chk("t1_enter_addr", addr, 0);
      chk("t1_enter_stb", sample_stb, 0);
      ok = 1;
      for (int k = 1; k <= 33; k++) begin
         tick();
         if (addr !== 4'(k) || sample_stb !== 1'b1 || period_done !== (4'(k) == 4'd0)) ok = 0;
      end
      chk("t1_step_seq", ok, 1);
      chk("t1_addr_end", addr, 1);

      // Test 2: div=3, one period = 64 cycles
      en = 1'b0; div = 16'd3;
      do_reset();
      en = 1'b1;
      tick();
      stb_cnt = 0; pd_cnt = 0;
      for (int k = 1; k <= 64; k++) begin
         tick();
         stb_cnt += int'(sample_stb);
         pd_cnt  += int'(period_done);
         if (k == 3) chk("t2_addr_k3", addr, 0);
         if (k == 4) chk("t2_addr_k4", addr, 1);
      end
      chk("t2_stb_cnt", stb_cnt, 16);
      chk("t2_pd_cnt", pd_cnt, 1);
      chk("t2_addr_wrap", addr, 0);

      // Test 3: switch change aligned to wrap; glitch that reverts is dropped
      en = 1'b0; div = 16'd0;
      do_reset();
      en = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) tick();
      chk("t3_addr5", addr, 5);
      sw_req = 2'b10;
      ok = 1;
      for (int k = 6; k <= 15; k++) begin
         tick();
         if ({sw4, sw3} !== 2'b00) ok = 0;
      end
      chk("t3_sel_held", ok, 1);
      chk("t3_addr15", addr, 15);
      tick();
      chk("t3_wrap_addr", addr, 0);
      chk("t3_wrap_sel", {sw4, sw3}, 2);
      for (int k = 0; k < 5; k++) tick();
      sw_req = 2'b00;
      for (int k = 0; k < 3; k++) tick();
      sw_req = 2'b10;
      ok = 1;
      for (int k = 9; k <= 16; k++) begin
         tick();
         if ({sw4, sw3} !== 2'b10) ok = 0;
      end
      chk("t3_glitch_addr", addr, 0);
      chk("t3_glitch_sel", ok, 1);

      // Test 4: one-shot with div=1
      en = 1'b0; div = 16'd1; one_shot = 1'b1; sw_req = 2'b00;
      do_reset();
      en = 1'b1;
      tick();
      stb_cnt = 0; pd_cnt = 0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         stb_cnt += int'(sample_stb);
         pd_cnt  += int'(period_done);
      end
      chk("t4_stb_cnt", stb_cnt, 16);
      chk("t4_pd_cnt", pd_cnt, 1);
      chk("t4_busy", busy, 0);
      chk("t4_addr", addr, 0);
      en = 1'b0;
      tick(); tick();
      chk("t4_idle_busy", busy, 0);
      chk("t4_idle_addr", addr, 0);

      // Test 5: drain to end of period, then drain cancelled mid-period
      div = 16'd0; one_shot = 1'b0;
      do_reset();
      en = 1'b1;
      tick();
      for (int k = 0; k < 7; k++) tick();
      chk("t5_addr7", addr, 7);
      en = 1'b0;
      ok = 1;
      for (int k = 8; k <= 15; k++) begin
         tick();
         if (addr !== 4'(k) || busy !== 1'b1) ok = 0;
      end
      chk("t5_drain_seq", ok, 1);
      tick();
      chk("t5_drain_addr", addr, 0);
      chk("t5_drain_busy", busy, 0);
      tick();
      chk("t5_idle_busy", busy, 0);
      en = 1'b1;
      tick();
      for (int k = 0; k < 7; k++) tick();
      en = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      chk("t5_addr10", addr, 10);
      en = 1'b1;
      ok = 1;
      for (int k = 11; k <= 17; k++) begin
         tick();
         if (addr !== 4'(k) || busy !== 1'b1 || sample_stb !== 1'b1) ok = 0;
      end
      chk("t5_rerun_seq", ok, 1);

      // Test 6: async reset mid-period, then restart latency
      en = 1'b0; div = 16'd5;
      do_reset();
      en = 1'b1;
      tick();
      for (int k = 0; k < 54; k++) tick();
      chk("t6_addr9", addr, 9);
      chk("t6_busy_pre", busy, 1);
      rst = 1'b1;
      #2;
      chk_reset_vals("t6_async");
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 6) chk("t6_addr_k6", addr, 0);
         if (k == 7) chk("t6_addr_k7", addr, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
